// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle control sequencer for the ALU/register-file datapath.
// One instruction per 4 cycles: IDLE (accept) -> DECODE -> EXECUTE -> WRITEBACK.
module alu_op_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  input  logic             zero,
  output logic [2:0]       ALUcontrol,
  output logic             alu_src,
  output logic [31:0]      imm_out,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic [4:0]       wr_addr,
  output logic             reg_write,
  output logic             branch_taken,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [2:0] ALU_NAND = 3'b000;
  localparam logic [2:0] ALU_ARS  = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_BNZ  = 3'b011;
  localparam logic [2:0] ALU_NOP  = 3'b111;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] instr_q;
  logic        write_q;
  logic        bnz_q;
  logic        illegal_q;

  logic [2:0]  dec_op;
  logic        dec_src;
  logic        dec_write;
  logic        dec_bnz;
  logic        dec_illegal;
  logic [4:0]  dec_wr;

  assign instr_ready = (state == IDLE);

  // Decode the latched instruction word into ALU opcode and control flags.
  always_comb begin
    dec_op      = ALU_NOP;
    dec_src     = 1'b0;
    dec_write   = 1'b0;
    dec_bnz     = 1'b0;
    dec_illegal = 1'b0;
    dec_wr      = 5'd0;
    if (instr_q == 32'd0) begin
      dec_op = ALU_NOP;
    end else if (instr_q[31:26] == 6'b000000) begin
      dec_write = 1'b1;
      dec_wr    = instr_q[15:11];
      case (instr_q[5:0])
        6'b100000: dec_op = ALU_ADD;
        6'b100010: dec_op = ALU_SUB;
        6'b100111: dec_op = ALU_NAND;
        6'b000011: dec_op = ALU_ARS;
        default: begin
          dec_write   = 1'b0;
          dec_wr      = 5'd0;
          dec_illegal = 1'b1;
        end
      endcase
    end else if (instr_q[31:26] == 6'b001000) begin
      dec_op    = ALU_ADD;
      dec_src   = 1'b1;
      dec_write = 1'b1;
      dec_wr    = instr_q[20:16];
    end else if (instr_q[31:26] == 6'b000101) begin
      dec_op  = ALU_BNZ;
      dec_bnz = 1'b1;
    end else begin
      dec_illegal = 1'b1;
    end
  end

  // Sequencer FSM with registered datapath controls, pulses and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      instr_q      <= 32'd0;
      write_q      <= 1'b0;
      bnz_q        <= 1'b0;
      illegal_q    <= 1'b0;
      ALUcontrol   <= ALU_NOP;
      alu_src      <= 1'b0;
      imm_out      <= 32'd0;
      rs_addr      <= 5'd0;
      rt_addr      <= 5'd0;
      wr_addr      <= 5'd0;
      reg_write    <= 1'b0;
      branch_taken <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
      retired_cnt  <= '0;
      taken_cnt    <= '0;
    end else begin
      reg_write    <= 1'b0;
      branch_taken <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state   <= DECODE;
          end
        end
        DECODE: begin
          rs_addr    <= instr_q[25:21];
          rt_addr    <= instr_q[20:16];
          imm_out    <= {{16{instr_q[15]}}, instr_q[15:0]};
          wr_addr    <= dec_wr;
          alu_src    <= dec_src;
          ALUcontrol <= dec_op;
          write_q    <= dec_write;
          bnz_q      <= dec_bnz;
          illegal_q  <= dec_illegal;
          state      <= EXECUTE;
        end
        EXECUTE: begin
          // zero is sampled on this edge; pulses appear in WRITEBACK
          reg_write    <= write_q;
          done         <= 1'b1;
          branch_taken <= bnz_q & zero;
          illegal      <= illegal_q;
          retired_cnt  <= retired_cnt + CNT_W'(1);
          if (bnz_q && zero) begin
            taken_cnt <= taken_cnt + CNT_W'(1);
          end
          state <= WRITEBACK;
        end
        WRITEBACK: begin
          ALUcontrol <= ALU_NOP;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and randomized checks against a latency-based reference model.
module tb_alu_op_sequencer;

  localparam int unsigned CW  = 4;
  localparam int          MOD = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic [31:0]   instr;
  logic          zero;
  logic          instr_ready;
  logic [2:0]    ALUcontrol;
  logic          alu_src;
  logic [31:0]   imm_out;
  logic [4:0]    rs_addr;
  logic [4:0]    rt_addr;
  logic [4:0]    wr_addr;
  logic          reg_write;
  logic          branch_taken;
  logic          done;
  logic          illegal;
  logic [CW-1:0] retired_cnt;
  logic [CW-1:0] taken_cnt;

  alu_op_sequencer #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .zero(zero), .ALUcontrol(ALUcontrol),
    .alu_src(alu_src), .imm_out(imm_out), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .wr_addr(wr_addr), .reg_write(reg_write), .branch_taken(branch_taken),
    .done(done), .illegal(illegal), .retired_cnt(retired_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic       src;
    logic       wen;
    logic       bnz;
    logic       ill;
    logic [4:0] wa;
  } dec_t;

  int tests = 0;
  int fails = 0;

  // Reference model: cycles elapsed since accept, plus retired/taken totals.
  int          age = 0;
  logic [31:0] m_instr = 32'd0;
  logic        m_zq = 1'b0;
  int          m_ret = 0;
  int          m_tak = 0;
  int          cyc = 0;
  int          last_acc = -100;
  int          acc_gap = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic dec_t ref_dec(input logic [31:0] w);
    dec_t d;
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    d = '{op: 3'b111, src: 1'b0, wen: 1'b0, bnz: 1'b0, ill: 1'b0, wa: 5'd0};
    if (w == 32'd0) begin
      d.op = 3'b111;
    end else if (op == 6'd0 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h27 || fn == 6'h03)) begin
      d.op  = (fn == 6'h20) ? 3'b010 : (fn == 6'h22) ? 3'b110 : (fn == 6'h27) ? 3'b000 : 3'b001;
      d.wen = 1'b1;
      d.wa  = w[15:11];
    end else if (op == 6'h08) begin
      d.op  = 3'b010;
      d.src = 1'b1;
      d.wen = 1'b1;
      d.wa  = w[20:16];
    end else if (op == 6'h05) begin
      d.op  = 3'b011;
      d.bnz = 1'b1;
    end else begin
      d.ill = 1'b1;
    end
    return d;
  endfunction

  task automatic compare();
    dec_t d;
    logic [31:0] imm_exp;
    d = ref_dec(m_instr);
    imm_exp = {{16{m_instr[15]}}, m_instr[15:0]};
    chk("instr_ready", 32'(instr_ready), 32'(age == 0));
    chk("ALUcontrol", 32'(ALUcontrol), (age >= 2) ? 32'(d.op) : 32'd7);
    if (age >= 2) begin
      chk("alu_src", 32'(alu_src), 32'(d.src));
      chk("rs_addr", 32'(rs_addr), 32'(m_instr[25:21]));
      chk("rt_addr", 32'(rt_addr), 32'(m_instr[20:16]));
      chk("imm_out", imm_out, imm_exp);
      if (d.wen) chk("wr_addr", 32'(wr_addr), 32'(d.wa));
    end
    chk("done", 32'(done), 32'(age == 3));
    chk("reg_write", 32'(reg_write), 32'(age == 3 && d.wen));
    chk("branch_taken", 32'(branch_taken), 32'(age == 3 && d.bnz && m_zq));
    chk("illegal", 32'(illegal), 32'(age == 3 && d.ill));
    chk("retired_cnt", 32'(retired_cnt), 32'(m_ret));
    chk("taken_cnt", 32'(taken_cnt), 32'(m_tak));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, compare at the falling edge.
  task automatic step(input logic r, input logic v, input logic [31:0] i, input logic z);
    dec_t d;
    logic dut_acc;
    rst = r;
    instr_valid = v;
    instr = i;
    zero = z;
    #1;
    dut_acc = instr_ready & v & ~r;
    @(posedge clk);
    cyc++;
    if (dut_acc) begin
      acc_gap = cyc - last_acc;
      last_acc = cyc;
    end
    if (r) begin
      age = 0;
      m_ret = 0;
      m_tak = 0;
    end else begin
      case (age)
        0: if (v) begin age = 1; m_instr = i; end
        1: age = 2;
        2: begin
          d = ref_dec(m_instr);
          m_zq = z;
          age = 3;
          m_ret = (m_ret + 1) % MOD;
          if (d.bnz && z) m_tak = (m_tak + 1) % MOD;
        end
        default: age = 0;
      endcase
    end
    @(negedge clk);
    compare();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0]  fn;
    r = $urandom();
    case ($urandom_range(0, 5))
      0: begin
        case ($urandom_range(0, 3))
          0: fn = 6'h20;
          1: fn = 6'h22;
          2: fn = 6'h27;
          default: fn = 6'h03;
        endcase
        return {6'b000000, r[25:6], fn};
      end
      1: return {6'b001000, r[25:0]};
      2: return {6'b000101, r[25:0]};
      3: return 32'd0;
      4: return {6'b000000, r[25:0]};
      default: return r;
    endcase
  endfunction

  task automatic drain();
    for (int k = 0; k < 4 && age != 0; k++) step(1'b0, 1'b0, $urandom(), 1'($urandom()));
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 32'd0;
    zero = 1'b0;

    // Reset with a valid instruction presented during reset: must not be accepted
    step(1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 32'h00430820, 1'b0);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_alu", 32'(ALUcontrol), 32'd7);
    chk("rst_addr", {17'd0, rs_addr, rt_addr, wr_addr}, 32'd0);
    chk("rst_imm", imm_out, 32'd0);
    chk("rst_cnt", 32'({retired_cnt, taken_cnt}), 32'd0);

    // ADD r1 = r2 + r3; busy-time instr changes must be ignored
    step(1'b0, 1'b1, 32'h00430820, 1'b0);
    step(1'b0, 1'b1, $urandom(), 1'b0);
    chk("add_rs", 32'(rs_addr), 32'd2);
    chk("add_rt", 32'(rt_addr), 32'd3);
    chk("add_alu_ex", 32'(ALUcontrol), 32'd2);
    step(1'b0, 1'b1, $urandom(), 1'b1);
    chk("add_wr", 32'(wr_addr), 32'd1);
    chk("add_we", 32'(reg_write), 32'd1);
    chk("add_done", 32'(done), 32'd1);
    chk("add_alu_wb", 32'(ALUcontrol), 32'd2);
    chk("add_ret", 32'(retired_cnt), 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("add_idle_alu", 32'(ALUcontrol), 32'd7);

    // ADDI with negative immediate
    step(1'b0, 1'b1, 32'h2022FFFC, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("addi_src", 32'(alu_src), 32'd1);
    chk("addi_imm", imm_out, 32'hFFFFFFFC);
    chk("addi_alu", 32'(ALUcontrol), 32'd2);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("addi_wr", 32'(wr_addr), 32'd2);
    chk("addi_we", 32'(reg_write), 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b1);

    // BNZ taken, then not taken; zero toggles outside EXECUTE
    step(1'b0, 1'b1, 32'h14400008, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("bnz1_taken", 32'(branch_taken), 32'd1);
    chk("bnz1_we", 32'(reg_write), 32'd0);
    chk("bnz1_cnt", 32'(taken_cnt), 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 32'h14400008, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("bnz0_taken", 32'(branch_taken), 32'd0);
    chk("bnz0_cnt", 32'(taken_cnt), 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b1);

    // Illegal encoding, then valid held high for back-to-back accepts
    step(1'b0, 1'b1, 32'hFC000000, 1'b0);
    step(1'b0, 1'b1, 32'hFC000000, 1'b0);
    step(1'b0, 1'b1, 32'hFC000000, 1'b0);
    chk("ill_alu", 32'(ALUcontrol), 32'd7);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_done", 32'(done), 32'd1);
    chk("ill_we", 32'(reg_write), 32'd0);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 32'h00221822, 1'($urandom()));
    chk("b2b_gap", 32'(acc_gap), 32'd4);
    drain();

    // Reset while a SUB is in EXECUTE
    step(1'b0, 1'b1, 32'h00221822, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    chk("mid_rst_ready", 32'(instr_ready), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_we", 32'(reg_write), 32'd0);
    chk("mid_rst_alu", 32'(ALUcontrol), 32'd7);
    chk("mid_rst_cnt", 32'({retired_cnt, taken_cnt}), 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("mid_rst_nodone", 32'(done), 32'd0);

    // 16 back-to-back NOPs wrap the 4-bit retired counter
    for (int n = 1; n <= 64; n++) begin
      step(1'b0, 1'b1, 32'd0, 1'($urandom()));
      if (n == 60) chk("wrap_15", 32'(retired_cnt), 32'd15);
      if (n == 64) chk("wrap_0", 32'(retired_cnt), 32'd0);
    end
    drain();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 2000; n++) begin
      step(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) != 0),
           rand_instr(), 1'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle control sequencer that drives the ALU control interface.
- Accepts one 32-bit instruction per handshake, decodes it into a 3-bit ALU opcode, steers operand select and register-file addresses, and samples the ALU zero flag.
- Issues write-back and branch pulses from that flag.
- Sits between instruction fetch and the ALU/register-file datapath.

Parameters:
- CNT_W, 16, width of the retired-instruction and taken-branch counters (wrap-around).

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous reset, active-high
- instr_valid  in  1  instruction present on instr
- instr  in  32  instruction word
- instr_ready  out  1  sequencer can accept; high only in IDLE
- zero  in  1  ALU flag: 1 when ALU in1 != 0
- ALUcontrol  out  3  000 NAND, 001 ARS, 010 ADD, 110 SUB, 011 BNZ, 111 NOP
- alu_src  out  1  0 = in2 from register rt, 1 = in2 from imm_out
- imm_out  out  32  sign-extended instr[15:0]
- rs_addr  out  5  instr[25:21]
- rt_addr  out  5  instr[20:16]
- wr_addr  out  5  destination register
- reg_write  out  1  one-cycle register-file write strobe
- branch_taken  out  1  one-cycle pulse, BNZ taken
- done  out  1  one-cycle pulse, instruction retired
- illegal  out  1  one-cycle pulse with done for an unrecognised encoding
- retired_cnt  out  CNT_W  count of done pulses
- taken_cnt  out  CNT_W  count of branch_taken pulses

Behaviour:
- All outputs are registered except instr_ready, which is (state == IDLE).
- Reset, sync, rst = 1 at edge:
  - state = IDLE
  - ALUcontrol = 111, alu_src = 0
  - imm_out, rs_addr, rt_addr and wr_addr = 0
  - reg_write, branch_taken, done and illegal = 0
  - both counters = 0
  - Reset overrides any state, including mid-instruction; the in-flight instruction is dropped with no pulses.
- Decode on opcode instr[31:26] and funct instr[5:0]:
  - op 000000 with funct 100000 -> ADD, funct 100010 -> SUB, funct 100111 -> NAND, funct 000011 -> ARS
    - alu_src = 0, wr_addr = instr[15:11], write = 1
  - op 001000 (ADDI) -> ADD, alu_src = 1, wr_addr = instr[20:16], write = 1
  - op 000101 (BNZ) -> BNZ, alu_src = 0, write = 0
  - op 000000 with all-zero word -> NOP, write = 0
  - Anything else -> NOP, write = 0, illegal flagged.
- FSM, one state per cycle:
  - IDLE: on instr_valid & instr_ready, latch instr, go to DECODE. ALUcontrol held at 111. If instr_valid is low, stay in IDLE.
  - DECODE: register rs_addr, rt_addr, imm_out, wr_addr and alu_src from the latched word. ALUcontrol stays 111. Go to EXECUTE.
  - EXECUTE: drive the decoded ALUcontrol; sample zero into zero_q at the end of the cycle. Go to WRITEBACK.
  - WRITEBACK:
    - ALUcontrol, alu_src and the addresses are held stable from EXECUTE.
    - reg_write = write, done = 1.
    - branch_taken = (BNZ & zero_q); illegal as decoded.
    - Next state IDLE; ALUcontrol returns to 111 on that edge.
- Latency: accept edge at T -> done high in cycle T+3. Throughput is one instruction per 4 cycles; instr_ready is low for 3 cycles after accept.
- instr is ignored outside the IDLE handshake; changes on instr while busy have no effect.
- Counters:
  - retired_cnt += 1 on each done; taken_cnt += 1 on each branch_taken.
  - Both wrap from 2^CNT_W-1 to 0 with no flag.
- zero is sampled only in EXECUTE; its value in other states is ignored.
- instr_valid asserted in the same cycle rst is high: not accepted.

Test Plan:
- Reset then idle:
  - rst high 2 cycles, instr_valid = 0 -> instr_ready = 1, ALUcontrol = 111, all pulses 0, counters 0.
- ADD:
  - instr = 0x00430820 (rs 2, rt 3, rd 1) accepted at T.
  - rs_addr = 2, rt_addr = 3 from T+2; ALUcontrol = 010 in T+2 and T+3.
  - reg_write = 1, wr_addr = 1, done = 1 in T+3; retired_cnt = 1.
- ADDI with negative immediate:
  - instr = 0x2022FFFC.
  - alu_src = 1, imm_out = 0xFFFFFFFC, wr_addr = 2, ALUcontrol = 010, reg_write pulse.
- BNZ, both outcomes:
  - instr = 0x14400008 with zero = 1 in EXECUTE -> branch_taken = 1, reg_write = 0, taken_cnt = 1.
  - Repeat with zero = 0 -> branch_taken = 0, taken_cnt stays 1.
- Illegal encoding and back-to-back instructions:
  - instr = 0xFC000000 -> ALUcontrol = 111, illegal = 1 and done = 1 same cycle, reg_write = 0.
  - With instr_valid held high, the next accept occurs exactly 4 cycles after the previous one.
- Reset mid-operation and counter wrap:
  - rst asserted in EXECUTE of a SUB -> next cycle IDLE, no done, no reg_write, counters 0.
  - With CNT_W = 4, 16 NOPs -> retired_cnt wraps to 0.
